// File: rtl/spi_slave_rx_tx_if.sv
// rtl/spi_slave_rx_tx_if.sv - SPI pins plus parallel TX/RX handshake bundle
interface spi_slave_rx_tx_if #(
    parameter int DATA_W = 8
);
    logic              spi_clk_i;
    logic              spi_cs_i;
    logic              spi_mosi_i;
    logic              spi_miso_o;
    logic [DATA_W-1:0] tx_data_i;
    logic              tx_valid_i;
    logic              tx_ready_o;
    logic [DATA_W-1:0] rx_data_o;
    logic              rx_valid_o;
    logic              busy_o;
    logic              tx_underrun_o;
    logic              frame_abort_o;

    modport slave (
        input  spi_clk_i, spi_cs_i, spi_mosi_i, tx_data_i, tx_valid_i,
        output spi_miso_o, tx_ready_o, rx_data_o, rx_valid_o, busy_o,
               tx_underrun_o, frame_abort_o
    );

    modport master (
        output spi_clk_i, spi_cs_i, spi_mosi_i, tx_data_i, tx_valid_i,
        input  spi_miso_o, tx_ready_o, rx_data_o, rx_valid_o, busy_o,
               tx_underrun_o, frame_abort_o
    );
endinterface

// File: rtl/spi_slave_rx_tx.sv
// rtl/spi_slave_rx_tx.sv - oversampled SPI mode 3 responder with one-deep TX holding register
module spi_slave_rx_tx #(
    parameter int              DATA_W      = 8,
    parameter int              SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] TX_IDLE   = 8'hFF
) (
    input logic               sys_clk,
    input logic               sys_rst,
    spi_slave_rx_tx_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q,   cs_prev_d;
    logic [SYNC_STAGES:0]   flush_q,     flush_d;
    logic                   armed_q,     armed_d;
    logic                   busy_q,      busy_d;
    logic                   done_q,      done_d;
    logic [CNT_W-1:0]       bit_cnt_q,   bit_cnt_d;
    logic [DATA_W-1:0]      rx_shift_q,  rx_shift_d;
    logic [DATA_W-1:0]      tx_shift_q,  tx_shift_d;
    logic                   hold_full_q, hold_full_d;
    logic [DATA_W-1:0]      hold_data_q, hold_data_d;
    logic                   miso_q,      miso_d;
    logic [DATA_W-1:0]      rx_data_q,   rx_data_d;
    logic                   rx_valid_q,  rx_valid_d;
    logic                   underrun_q,  underrun_d;
    logic                   abort_q,     abort_d;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_clk_i};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_i};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi_i};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        flush_d     = {flush_q[SYNC_STAGES-1:0], 1'b1};
        armed_d     = armed_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        abort_d     = 1'b0;
        miso_d      = busy_q ? tx_shift_q[DATA_W-1] : 1'b0;

        // Only trust CS once the synchroniser holds real pin samples showing CS high,
        // so a frame already in flight at reset release is ignored.
        if (flush_q[SYNC_STAGES] && cs_s && cs_prev_q) begin
            armed_d = 1'b1;
        end

        if (busy_q) begin
            if (done_q) begin
                rx_data_d  = rx_shift_q;
                rx_valid_d = 1'b1;
                bit_cnt_d  = '0;
            end
            if (cs_rise) begin
                busy_d     = 1'b0;
                bit_cnt_d  = '0;
                rx_shift_d = '0;
                tx_shift_d = '0;
                abort_d    = (bit_cnt_q != '0) && !done_q;
            end else begin
                if (sclk_fall) begin
                    if (bit_cnt_q == '0) begin
                        if (hold_full_q) begin
                            tx_shift_d  = hold_data_q;
                            hold_full_d = 1'b0;
                        end else begin
                            tx_shift_d = TX_IDLE;
                            underrun_d = 1'b1;
                        end
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                    end
                end
                if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    done_d     = (bit_cnt_q == CNT_W'(DATA_W - 1));
                end
            end
        end else if (armed_q && cs_fall) begin
            busy_d = 1'b1;
        end

        // Accept after the word-start load so a same-cycle push is held, not bypassed.
        if (bus.tx_valid_i && !hold_full_q) begin
            hold_full_d = 1'b1;
            hold_data_d = bus.tx_data_i;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sclk_sync_q <= '1;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b1;
            cs_prev_q   <= 1'b1;
            flush_q     <= '0;
            armed_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            miso_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            flush_q     <= flush_d;
            armed_q     <= armed_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            miso_q      <= miso_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            abort_q     <= abort_d;
        end
    end

    assign bus.spi_miso_o    = miso_q;
    assign bus.tx_ready_o    = ~hold_full_q;
    assign bus.rx_data_o     = rx_data_q;
    assign bus.rx_valid_o    = rx_valid_q;
    assign bus.busy_o        = busy_q;
    assign bus.tx_underrun_o = underrun_q;
    assign bus.frame_abort_o = abort_q;
endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// tb/tb_spi_slave_rx_tx.sv - scoreboard bench driving a mode 3 SPI master against spi_slave_rx_tx
module tb_spi_slave_rx_tx;
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    spi_slave_rx_tx_if #(.DATA_W(8)) bus ();

    spi_slave_rx_tx #(.DATA_W(8), .SYNC_STAGES(2), .TX_IDLE(8'hFF)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    int n_total = 0;
    int n_pass  = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    int rx_cnt = 0, underrun_cnt = 0, abort_cnt = 0;
    int exp_rx = 0, exp_underrun = 0, exp_abort = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Word-level model: a word start takes the oldest accepted TX word, else the idle pattern.
    function automatic logic [7:0] model_next();
        if (tx_q.size() != 0) return tx_q.pop_front();
        exp_underrun++;
        return 8'hFF;
    endfunction

    task automatic wait_neg(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic spi_bits(input logic [7:0] w, input int nbits, output logic [7:0] m);
        m = '0;
        for (int i = 0; i < nbits; i++) begin
            bus.spi_clk_i  = 1'b0;
            bus.spi_mosi_i = w[7-i];
            wait_neg(4);
            m = {m[6:0], bus.spi_miso_o};
            bus.spi_clk_i = 1'b1;
            wait_neg(4);
        end
    endtask

    task automatic spi_word(input logic [7:0] w, input string nm);
        logic [7:0] exp_m, got;
        exp_m = model_next();
        rx_q.push_back(w);
        exp_rx++;
        spi_bits(w, 8, got);
        check({nm, "_miso"}, got, exp_m);
    endtask

    task automatic cs_low();
        bus.spi_cs_i = 1'b0;
        wait_neg(6);
    endtask

    task automatic cs_high();
        bus.spi_cs_i = 1'b1;
        wait_neg(8);
    endtask

    task automatic tx_push(input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        bus.tx_data_i  = d;
        bus.tx_valid_i = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            if (bus.tx_ready_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
        @(negedge sys_clk);
        bus.tx_valid_i = 1'b0;
        if (ok) tx_q.push_back(d);
        check("tx_accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic check_counts(input string nm);
        check({nm, "_rx_cnt"}, rx_cnt, exp_rx);
        check({nm, "_underrun_cnt"}, underrun_cnt, exp_underrun);
        check({nm, "_abort_cnt"}, abort_cnt, exp_abort);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_miso"}, bus.spi_miso_o, 0);
        check({nm, "_tx_ready"}, bus.tx_ready_o, 1);
        check({nm, "_rx_data"}, bus.rx_data_o, 0);
        check({nm, "_rx_valid"}, bus.rx_valid_o, 0);
        check({nm, "_busy"}, bus.busy_o, 0);
        check({nm, "_underrun"}, bus.tx_underrun_o, 0);
        check({nm, "_abort"}, bus.frame_abort_o, 0);
    endtask

    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(negedge sys_clk);
            if (bus.tx_underrun_o) underrun_cnt++;
            if (bus.frame_abort_o) abort_cnt++;
            if (bus.rx_valid_o) begin
                rx_cnt++;
                check("rx_expected_word", {31'd0, rx_q.size() != 0}, 32'd1);
                if (rx_q.size() != 0) begin
                    e = rx_q.pop_front();
                    check("rx_data", bus.rx_data_o, e);
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        logic [7:0] dummy, rnd;
        bus.spi_clk_i  = 1'b1;
        bus.spi_cs_i   = 1'b1;
        bus.spi_mosi_i = 1'b0;
        bus.tx_data_i  = '0;
        bus.tx_valid_i = 1'b0;
        wait_neg(3);
        sys_rst = 1'b0;
        wait_neg(2);
        check_reset_outputs("reset");
        wait_neg(8);

        // Preloaded word goes out while 3C comes in.
        tx_push(8'hA5);
        check("t1_ready_full", bus.tx_ready_o, 0);
        cs_low();
        check("t1_busy", bus.busy_o, 1);
        spi_word(8'h3C, "t1");
        check("t1_ready_empty", bus.tx_ready_o, 1);
        cs_high();
        check_counts("t1");

        // Empty holding register: idle pattern and underrun.
        cs_low();
        spi_word(8'h00, "t2");
        cs_high();
        check_counts("t2");

        // Back-to-back words with pushes racing the word boundaries.
        tx_push(8'h11);
        cs_low();
        fork
            begin
                tx_push(8'h22);
                tx_push(8'h33);
            end
            begin
                spi_word(8'h01, "t3a");
                spi_word(8'h80, "t3b");
                spi_word(8'hFF, "t3c");
            end
        join
        cs_high();
        check_counts("t3");

        // Partial word aborts; the word it loaded is lost.
        tx_push(8'h3E);
        cs_low();
        dummy = model_next();
        spi_bits(8'hC7, 5, dummy);
        bus.spi_cs_i = 1'b1;
        exp_abort++;
        wait_neg(8);
        cs_low();
        spi_word(8'h5A, "t4");
        cs_high();
        check_counts("t4");

        // Push while full must stall, then land after the next load.
        tx_push(8'h77);
        fork
            tx_push(8'hC3);
            begin
                wait_neg(10);
                check("t5_ready_stall", bus.tx_ready_o, 0);
                cs_low();
                spi_word(8'h24, "t5a");
                spi_word(8'hB1, "t5b");
                cs_high();
            end
        join
        check_counts("t5");

        // Random words in one frame, random presence of TX data.
        for (int r = 0; r < 6; r++) begin
            rnd = 8'($urandom);
            if ($urandom_range(0, 1) == 1) tx_push(8'($urandom));
            cs_low();
            spi_word(rnd, "rand");
            cs_high();
        end
        check_counts("rand");

        // Reset mid-word; the rest of that frame is ignored.
        tx_push(8'h6B);
        cs_low();
        dummy = model_next();
        spi_bits(8'hE1, 3, dummy);
        sys_rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        tx_q.delete();
        wait_neg(2);
        sys_rst = 1'b0;
        spi_bits(8'hE1, 5, dummy);
        wait_neg(4);
        check("t6_ignored_busy", bus.busy_o, 0);
        cs_high();
        check_counts("t6_ignored");
        cs_low();
        spi_word(8'h96, "t6");
        cs_high();
        check("t6_rx_data", bus.rx_data_o, 8'h96);
        check_counts("t6");
        check("rx_queue_drained", rx_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
